// File: rtl/ekf_alu_pkg.sv
// Shared types and helpers for the Kalman-gain divider: FSM encoding,
// saturation constant and per-channel slice selection.
package ekf_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV,
    ST_STORE,
    ST_DONE
  } kg_state_e;

  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Quotient LSB index of a channel's output slice, packed 8 bits per channel.
  function automatic logic [7:0] sel_lsb_of(input logic [63:0] sel, input logic [7:0] ch);
    return sel[ch*8 +: 8];
  endfunction

endpackage

// File: rtl/k_gain_udiv_core.sv
// Unsigned serial restoring divider: one quotient bit per step, MSB first.
// The divisor must be held stable by the caller for the whole run.
module k_gain_udiv_core #(
  parameter int NUM_W = 48,
  parameter int DEN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [NUM_W-1:0] dividend,
  input  logic [DEN_W-1:0] divisor,
  output logic [NUM_W-1:0] quotient,
  output logic [DEN_W:0]   remainder
);

  logic [NUM_W-1:0] dvd_q;
  logic [NUM_W-1:0] quo_q;
  logic [DEN_W:0]   rem_q;
  logic [DEN_W:0]   trial;
  logic             fits;

  always_comb begin
    trial = {rem_q[DEN_W-1:0], dvd_q[NUM_W-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
    end else if (load) begin
      dvd_q <= dividend;
      quo_q <= '0;
      rem_q <= '0;
    end else if (step) begin
      dvd_q <= {dvd_q[NUM_W-2:0], 1'b0};
      quo_q <= {quo_q[NUM_W-2:0], fits};
      rem_q <= fits ? (trial - {1'b0, divisor}) : trial;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/k_gain_div.sv
// N-channel Kalman-gain divider sharing one serial divider across channels.
// Define K_GAIN_ROUND_EN for round-half-away-from-zero; default truncates.
module k_gain_div
  import ekf_alu_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int NUM_W = 48,
  parameter int DEN_W = 24,
  parameter int OUT_W = 24,
  parameter logic [N_CH*8-1:0] SEL_LSB = 16'h0104
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CH*NUM_W-1:0] num,
  input  logic [DEN_W-1:0]      den,
  output logic [N_CH*OUT_W-1:0] k_out,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH-1:0]       ovf,
  output logic                  dz
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(NUM_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [OUT_W-2:0] MAG_MAX  = (OUT_W-1)'(sat_max(OUT_W));

  kg_state_e         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_load, div_step, accept;

  logic [NUM_W-1:0]  num_abs [N_CH];
  logic [NUM_W-1:0]  mag_q   [N_CH];
  logic [N_CH-1:0]   nsgn_q;
  logic [DEN_W-1:0]  den_abs, den_mag_q;
  logic              dsgn_q, den_zero_q;

  logic [N_CH*OUT_W-1:0] k_q;
  logic [N_CH-1:0]       ovf_q;
  logic                  dz_q;

  logic [NUM_W-1:0]  quo, body;
  logic [DEN_W:0]    div_rem_unused;
  logic [7:0]        sel_s;
  logic              hi, rnd, sat, sgn, ovf_val;
  logic [OUT_W-1:0]  m_sum, k_val;
  logic [OUT_W-2:0]  m;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_abs
    logic [NUM_W-1:0] num_ch;
    assign num_ch      = num[gi*NUM_W +: NUM_W];
    assign num_abs[gi] = num_ch[NUM_W-1] ? -num_ch : num_ch;
  end

  assign den_abs = den[DEN_W-1] ? -den : den;
  assign accept  = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PREP;
          ch_d    = '0;
        end
      end
      ST_PREP: begin
        div_load = 1'b1;
        cnt_d    = '0;
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_STORE;
      end
      ST_STORE: begin
        ch_d    = ch_q + 1'b1;
        state_d = (ch_q == CH_LAST) ? ST_DONE : ST_PREP;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  k_gain_udiv_core #(
    .NUM_W(NUM_W),
    .DEN_W(DEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_q[ch_q]),
    .divisor  (den_mag_q),
    .quotient (quo),
    .remainder(div_rem_unused)
  );

  // Slice, round, saturate and sign the finished quotient of channel ch_q.
  always_comb begin
    sel_s = sel_lsb_of(64'(SEL_LSB), 8'(ch_q));
`ifdef K_GAIN_ROUND_EN
    begin
      logic [NUM_W:0] ext;
      ext  = {quo, 1'b0} >> sel_s;
      body = ext[NUM_W:1];
      rnd  = ext[0];
    end
`else
    body = quo >> sel_s;
    rnd  = 1'b0;
`endif
    hi    = |(body >> (OUT_W - 1));
    m_sum = {1'b0, body[OUT_W-2:0]} + OUT_W'(rnd);
    sat   = hi | m_sum[OUT_W-1];
    if (den_zero_q) begin
      m       = (mag_q[ch_q] == '0) ? '0 : MAG_MAX;
      sgn     = nsgn_q[ch_q];
      ovf_val = 1'b0;
    end else begin
      m       = sat ? MAG_MAX : m_sum[OUT_W-2:0];
      sgn     = nsgn_q[ch_q] ^ dsgn_q;
      ovf_val = sat;
    end
    k_val = sgn ? -{1'b0, m} : {1'b0, m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) mag_q[i] <= '0;
      nsgn_q     <= '0;
      den_mag_q  <= '0;
      dsgn_q     <= 1'b0;
      den_zero_q <= 1'b0;
      k_q        <= '0;
      ovf_q      <= '0;
      dz_q       <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N_CH; i++) begin
          mag_q[i]  <= num_abs[i];
          nsgn_q[i] <= num[i*NUM_W + NUM_W - 1];
        end
        den_mag_q  <= den_abs;
        dsgn_q     <= den[DEN_W-1];
        den_zero_q <= (den == '0);
        ovf_q      <= '0;
        dz_q       <= 1'b0;
      end
      if (state_q == ST_STORE) begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch_q == CH_W'(i)) begin
            k_q[i*OUT_W +: OUT_W] <= k_val;
            ovf_q[i]              <= ovf_val;
          end
        end
        dz_q <= den_zero_q;
      end
    end
  end

  assign k_out = k_q;
  assign ovf   = ovf_q;
  assign dz    = dz_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_k_gain_div.sv
// Directed and randomized bench for k_gain_div with an arithmetic reference model.
module tb_k_gain_div;

  localparam int    SEL0 = 4;
  localparam int    SEL1 = 1;
  localparam longint MAXM = 64'h7FFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [95:0] num = '0;
  logic [23:0] den = '0;
  logic [47:0] k_out;
  logic        busy, done, dz;
  logic [1:0]  ovf;

  int checks = 0;
  int errors = 0;

  k_gain_div dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .num  (num),
    .den  (den),
    .k_out(k_out),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [47:0] n, input logic [23:0] d, input int ch,
                                output logic [23:0] k, output logic o);
    longint sn, sd, nm, dm, q, m, kv;
    int     s;
    bit     sg;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    nm = (sn < 0) ? -sn : sn;
    dm = (sd < 0) ? -sd : sd;
    o  = 1'b0;
    if (dm == 0) begin
      m  = (nm == 0) ? 0 : MAXM;
      sg = (sn < 0);
    end else begin
      q = nm / dm;
      s = (ch == 0) ? SEL0 : SEL1;
`ifdef K_GAIN_ROUND_EN
      if (s > 0) q = q + (longint'(1) << (s - 1));
`endif
      m = q >> s;
      if (m > MAXM) begin
        m = MAXM;
        o = 1'b1;
      end
      sg = (sn < 0) != (sd < 0);
    end
    kv = sg ? -m : m;
    k  = kv[23:0];
  endfunction

  task automatic run_case(input logic [47:0] n0, input logic [47:0] n1,
                          input logic [23:0] d, input string tag);
    logic [23:0] ek0, ek1;
    logic        eo0, eo1;
    logic [63:0] junk;
    int          cyc;
    model(n0, d, 0, ek0, eo0);
    model(n1, d, 1, ek1, eo1);
    @(negedge clk);
    num   = {n1, n0};
    den   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    junk  = {$urandom(), $urandom()};
    num   = {junk[47:0], junk[63:16]};
    den   = junk[23:0];
    chk({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'd100);
    chk({tag, " k0"}, 64'(k_out[23:0]), 64'(ek0));
    chk({tag, " k1"}, 64'(k_out[47:24]), 64'(ek1));
    chk({tag, " ovf"}, 64'(ovf), 64'({eo1, eo0}));
    chk({tag, " dz"}, 64'(dz), 64'(d == 24'd0));
    $display("run %s num0=%h num1=%h den=%h k_out=%h ovf=%b dz=%b cycles=%0d",
             tag, n0, n1, d, k_out, ovf, dz, cyc);
    @(posedge clk);
    #1;
    chk({tag, " idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int          cyc, ndone, done_cyc;
    logic [63:0] a, b, c;
    logic [47:0] n0, n1;
    logic [23:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset k_out", 64'(k_out), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);
    chk("reset dz", 64'(dz), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_case(48'h2000_0000_0000, 48'h2000_0000_0000, 24'h400000, "t1");
    chk("t1 k0 vec", 64'(k_out[23:0]), 64'h080000);
    chk("t1 k1 vec", 64'(k_out[47:24]), 64'h400000);

    run_case(48'h2000_0000_0000, 48'hE000_0000_0000, 24'h400000, "t2a");
    chk("t2a k1 vec", 64'(k_out[47:24]), 64'hC00000);
    run_case(48'h2000_0000_0000, 48'h2000_0000_0000, 24'hC00000, "t2b");
    chk("t2b k1 vec", 64'(k_out[47:24]), 64'hC00000);

    run_case(48'd1, 48'h7FFF_FFFF_FFFF, 24'd1, "t3a");
    chk("t3a k1 vec", 64'(k_out[47:24]), 64'h7FFFFF);
    chk("t3a ovf1 vec", 64'(ovf[1]), 64'd1);
    run_case(48'd1, 48'h8000_0000_0001, 24'd1, "t3b");
    chk("t3b k1 vec", 64'(k_out[47:24]), 64'h800001);

    run_case(48'd5, -48'd5, 24'd0, "t4");
    chk("t4 k0 vec", 64'(k_out[23:0]), 64'h7FFFFF);
    chk("t4 k1 vec", 64'(k_out[47:24]), 64'h800001);
    chk("t4 dz vec", 64'(dz), 64'd1);

    run_case(48'd0, 48'd3, 24'd1, "t6");
`ifdef K_GAIN_ROUND_EN
    chk("t6 k1 vec", 64'(k_out[47:24]), 64'h000002);
`else
    chk("t6 k1 vec", 64'(k_out[47:24]), 64'h000001);
`endif

    // Start held high through a run must give exactly one done.
    @(negedge clk);
    num   = {48'h2000_0000_0000, 48'h2000_0000_0000};
    den   = 24'h400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0; ndone = 0; done_cyc = -1;
    while (cyc < 130) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
      end
      if (cyc == 101) start = 1'b0;
    end
    chk("t5 done count", 64'(ndone), 64'd1);
    chk("t5 done cycle", 64'(done_cyc), 64'd100);
    chk("t5 idle", 64'(busy), 64'd0);
    $display("run t5 held start done_count=%0d done_cycle=%0d", ndone, done_cyc);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    num   = {48'h2000_0000_0000, 48'hE000_0000_0000};
    den   = 24'h400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("t5 mid k0", 64'(k_out[23:0]), 64'hF80000);
    #1;
    rst = 1'b1;
    #1;
    chk("t5 rst busy", 64'(busy), 64'd0);
    chk("t5 rst done", 64'(done), 64'd0);
    chk("t5 rst k_out", 64'(k_out), 64'd0);
    $display("run t5 async reset busy=%b done=%b k_out=%h", busy, done, k_out);
    @(negedge clk);
    rst = 1'b0;
    run_case(48'h0000_0123_4567, 48'hFFFF_F000_0000, 24'h001234, "t5c");

    for (int r = 0; r < 24; r++) begin
      a  = {$urandom(), $urandom()};
      b  = {$urandom(), $urandom()};
      c  = {$urandom(), $urandom()};
      n0 = a[47:0] >> $urandom_range(0, 40);
      n1 = b[47:0] >> $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 1) n0 = -n0;
      if ($urandom_range(0, 1) == 1) n1 = -n1;
      d = c[23:0] >> $urandom_range(0, 23);
      if ($urandom_range(0, 1) == 1) d = -d;
      if (r % 6 == 5) d = 24'd0;
      if (r == 7) n0 = 48'h8000_0000_0000;
      if (r == 8) d = 24'h800000;
      if (r == 9) n1 = 48'd0;
      run_case(n0, n1, d, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
